vga_capture: RTL and testbench
==============================

VGA_CAPTURE -- requirements
Module: vga_capture

Interface
REQ-001 Parameter hz_visible, default 640: captured pixels per line.
REQ-002 Parameter hz_whole, default 800: expected clocks per line.
REQ-003 Parameter hz_start, default 49: value of hc at which the first visible pixel is sampled (48 back porch plus 1 source output register).
REQ-004 Parameter vt_visible, default 400: captured lines per frame.
REQ-005 Parameter vt_whole, default 449: expected lines per frame.
REQ-006 Parameter vt_start, default 35: value of vc holding the first visible line.
REQ-007 CLOCK  in  1  pixel clock (25 MHz); the design has one clock; all logic is on the rising edge.
REQ-008 RESET  in  1  asynchronous, active-high reset.
REQ-009 VGA_R, VGA_G, VGA_B  in  4 each  incoming pixel colour.
REQ-010 VGA_HS  in  1  horizontal sync; active low, 96 clocks.
REQ-011 VGA_VS  in  1  vertical sync; active high, 2 lines.
REQ-012 FB_WE  out  1  framebuffer write strobe.
REQ-013 FB_ADDR  out  18  framebuffer address, equal to Y*640+X.
REQ-014 FB_DATA  out  12  captured pixel {R,G,B}.
REQ-015 LOCKED  out  1  the timing matches the parameters.
REQ-016 FRAME_DONE  out  1  one-clock pulse marking the end of a fully captured frame.
REQ-017 LINE_LEN  out  11  length of the last measured line, in clocks.
REQ-018 FRAME_LINES  out  10  number of lines in the last measured frame.

Function
REQ-019 All inputs SHALL pass through 2 register stages (s2). A third register (s3) SHALL hold the previous HS/VS values. RGB SHALL be delayed identically.
REQ-020 HS rising edge (hs_rise) SHALL be s2=1 with s3=0. VS falling edge (vs_fall) SHALL be s2=0 with s3=1.
REQ-021 hc (11 bits) SHALL load 0 on hs_rise; otherwise it increments, saturating at 2047.
REQ-022 vc (10 bits) SHALL load 0 on vs_fall; otherwise it increments on hs_rise, saturating at 1023. vs_fall takes priority over a simultaneous hs_rise.
REQ-023 On hs_rise, LINE_LEN SHALL load hc+1. On vs_fall, FRAME_LINES SHALL load vc+1.
REQ-024 A line SHALL be bad when hs_rise occurs with hc != hz_whole-1. A frame SHALL be bad when vs_fall occurs with vc != vt_whole-1.
REQ-025 Watchdog: hc reaching 2*hz_whole with no hs_rise SHALL count as a bad line.
REQ-026 FSM states SHALL be SEARCH, MEASURE and LOCK; the reset state is SEARCH.
REQ-027 SEARCH -> MEASURE on vs_fall.
REQ-028 MEASURE SHALL track a sticky error flag, cleared on entry and on every vs_fall. At vs_fall: go to LOCK if the flag is clear and the frame is good; otherwise stay in MEASURE.
REQ-029 LOCK -> SEARCH on any bad line, bad frame or watchdog; the transition SHALL take effect on the next clock.
REQ-030 LOCKED SHALL be 1 exactly when the state is LOCK.
REQ-031 Capture window: state LOCK, hc in [hz_start, hz_start+hz_visible-1], and vc in [vt_start, vt_start+vt_visible-1].
REQ-032 Inside the window, FB_WE, FB_DATA and FB_ADDR SHALL be registered with 1 clock of latency from the s2 sample.
REQ-033 The address counter SHALL reset to 0 on vs_fall and increment after each write. It is never wrapped: the count reaches at most 255999.
REQ-034 Outside the window, FB_WE SHALL be 0. FB_ADDR and FB_DATA SHALL hold their last values.
REQ-035 FRAME_DONE SHALL pulse for 1 clock on vs_fall when the state was LOCK for the whole preceding frame and that frame is good.
REQ-036 FRAME_DONE SHALL NOT pulse on the MEASURE -> LOCK transition.
REQ-037 When the state leaves LOCK mid-frame, writes SHALL stop immediately. Partial frames SHALL NOT raise FRAME_DONE.

Reset
REQ-038 RESET=1 SHALL immediately clear the following: FB_WE, FB_ADDR, FB_DATA, FRAME_DONE, LOCKED, LINE_LEN, FRAME_LINES, hc, vc, the address counter, the error flag and all sync registers. The sync registers clear to HS=1 and VS=0.
REQ-039 After reset the state SHALL be SEARCH.
REQ-040 Reset asserted mid-frame SHALL abort capture. Relock SHALL require the full SEARCH -> MEASURE -> LOCK sequence.

Verification
REQ-041 Drive the team 640x400 test-pattern generator from reset. LOCKED SHALL rise at the 2nd vs_fall. There SHALL be no writes before the 3rd frame. The 3rd frame SHALL produce exactly 256000 writes, followed by a FRAME_DONE pulse.
REQ-042 Check the captured data: addr 0 = 12'hFFF; addr 657 (X=17, Y=1) = 12'h800; addr 11537 (X=17, Y=18) = 12'h000. LINE_LEN SHALL be 800 and FRAME_LINES SHALL be 449.
REQ-043 While locked, shorten one line to 799 clocks. LOCKED SHALL drop 1 clock after that hs_rise and FB_WE SHALL stay 0. There SHALL be no FRAME_DONE for that frame. Relock SHALL follow 2 frames later.
REQ-044 While locked, hold HS high. LOCKED SHALL drop 1 clock after hc reaches 1600.
REQ-045 Assert RESET mid-line during capture. FB_WE and LOCKED SHALL go to 0 immediately, and all outputs SHALL hold 0 until RESET releases.
REQ-046 Drive 450-line frames. LOCKED SHALL never assert, and FRAME_LINES SHALL read 450.

Source files
------------

// File: rtl/vga_capture_if.sv
// VGA capture bundle: incoming VGA pixel/sync lines and
// framebuffer write port plus lock/measurement status.
interface vga_capture_if;
  logic [3:0]  VGA_R;
  logic [3:0]  VGA_G;
  logic [3:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        FB_WE;
  logic [17:0] FB_ADDR;
  logic [11:0] FB_DATA;
  logic        LOCKED;
  logic        FRAME_DONE;
  logic [10:0] LINE_LEN;
  logic [9:0]  FRAME_LINES;

  modport master (
    output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
    input  FB_WE, FB_ADDR, FB_DATA, LOCKED,
    input  FRAME_DONE, LINE_LEN, FRAME_LINES
  );

  modport slave (
    input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS,
    output FB_WE, FB_ADDR, FB_DATA, LOCKED,
    output FRAME_DONE, LINE_LEN, FRAME_LINES
  );
endinterface

// File: rtl/vga_capture.sv
// VGA frame grabber: syncs VGA input, measures line/frame timing,
// locks onto the expected mode and writes visible pixels to a framebuffer.
// Ports: CLOCK, RESET (async, active high); vga (slave):
//   VGA_R/G/B/HS/VS in; FB_WE/ADDR/DATA, LOCKED, FRAME_DONE,
//   LINE_LEN, FRAME_LINES out.
module vga_capture #(
  parameter int hz_visible = 640,
  parameter int hz_whole   = 800,
  parameter int hz_start   = 49,
  parameter int vt_visible = 400,
  parameter int vt_whole   = 449,
  parameter int vt_start   = 35
) (
  input logic         CLOCK,
  input logic         RESET,
  vga_capture_if.slave vga
);

  typedef enum logic [1:0] {
    SEARCH, MEASURE, LOCK
  } state_e;

  localparam logic [10:0] HZ_LAST = 11'(hz_whole - 1);
  localparam logic [10:0] WDOG    = 11'(2 * hz_whole);
  localparam logic [10:0] X_LO    = 11'(hz_start);
  localparam logic [10:0] X_HI    = 11'(hz_start + hz_visible - 1);
  localparam logic [9:0]  VT_LAST = 10'(vt_whole - 1);
  localparam logic [9:0]  Y_LO    = 10'(vt_start);
  localparam logic [9:0]  Y_HI    = 10'(vt_start + vt_visible - 1);
  // sync word {R,G,B,HS,VS}; idle HS=1, VS=0
  localparam logic [13:0] SYNC_RST = 14'b10;

  state_e      state_q, state_d;
  logic [13:0] s1_q, s2_q;
  logic        hs3_q, vs3_q;
  logic [10:0] hc_q, hc_d;
  logic [9:0]  vc_q, vc_d;
  logic [10:0] len_q, len_d;
  logic [9:0]  lines_q, lines_d;
  logic        err_q, err_d;
  logic        full_q, full_d;
  logic        we_q, we_d;
  logic        done_q, done_d;
  logic [17:0] cnt_q, cnt_d;
  logic [17:0] fa_q, fa_d;
  logic [11:0] fdat_q, fdat_d;

  logic hs_rise, vs_fall;
  logic line_err, bad_frame, in_win;

  always_comb begin
    hs_rise   = s2_q[1] & ~hs3_q;
    vs_fall   = ~s2_q[0] & vs3_q;
    // a long-missing HS rise counts as a bad line
    line_err  = (hs_rise && hc_q != HZ_LAST) ||
                (!hs_rise && hc_q == WDOG);
    bad_frame = vs_fall && vc_q != VT_LAST;
    in_win    = state_q == LOCK &&
                hc_q >= X_LO && hc_q <= X_HI &&
                vc_q >= Y_LO && vc_q <= Y_HI;

    hc_d = hc_q;
    if (hs_rise)
      hc_d = '0;
    else if (hc_q != 11'h7FF)
      hc_d = hc_q + 11'd1;

    vc_d = vc_q;
    if (vs_fall)
      vc_d = '0;
    else if (hs_rise && vc_q != 10'h3FF)
      vc_d = vc_q + 10'd1;

    len_d   = hs_rise ? hc_q + 11'd1 : len_q;
    lines_d = vs_fall ? vc_q + 10'd1 : lines_q;

    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      SEARCH: begin
        if (vs_fall) begin
          state_d = MEASURE;
          err_d   = 1'b0;
        end
      end
      MEASURE: begin
        if (vs_fall) begin
          err_d = 1'b0;
          if (!err_q && !line_err && !bad_frame)
            state_d = LOCK;
        end else if (line_err) begin
          err_d = 1'b1;
        end
      end
      LOCK: begin
        if (line_err || bad_frame)
          state_d = SEARCH;
      end
      default: state_d = SEARCH;
    endcase

    // full: LOCK held since the last frame boundary
    full_d = vs_fall ? (state_d == LOCK)
                     : (full_q && state_q == LOCK);
    done_d = vs_fall && state_q == LOCK &&
             full_q && state_d == LOCK;

    we_d   = in_win;
    fa_d   = fa_q;
    fdat_d = fdat_q;
    cnt_d  = cnt_q;
    if (in_win) begin
      fa_d   = cnt_q;
      fdat_d = s2_q[13:2];
      cnt_d  = cnt_q + 18'd1;
    end
    if (vs_fall)
      cnt_d = '0;
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q <= SEARCH;
      s1_q    <= SYNC_RST;
      s2_q    <= SYNC_RST;
      hs3_q   <= 1'b1;
      vs3_q   <= 1'b0;
      hc_q    <= '0;
      vc_q    <= '0;
      len_q   <= '0;
      lines_q <= '0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      fa_q    <= '0;
      fdat_q  <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= {vga.VGA_R, vga.VGA_G, vga.VGA_B,
                  vga.VGA_HS, vga.VGA_VS};
      s2_q    <= s1_q;
      hs3_q   <= s2_q[1];
      vs3_q   <= s2_q[0];
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      len_q   <= len_d;
      lines_q <= lines_d;
      err_q   <= err_d;
      full_q  <= full_d;
      we_q    <= we_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      fa_q    <= fa_d;
      fdat_q  <= fdat_d;
    end
  end

  assign vga.FB_WE       = we_q;
  assign vga.FB_ADDR     = fa_q;
  assign vga.FB_DATA     = fdat_q;
  assign vga.LOCKED      = state_q == LOCK;
  assign vga.FRAME_DONE  = done_q;
  assign vga.LINE_LEN    = len_q;
  assign vga.FRAME_LINES = lines_q;

endmodule

// File: tb/tb_vga_capture.sv
// Testbench for vga_capture: scaled-down video mode, random pixels,
// line/frame level reference model and a write scoreboard.
module tb_vga_capture;
  localparam int HV   = 24;
  localparam int HW   = 48;
  localparam int HST  = 13;
  localparam int VV   = 10;
  localparam int VW   = 16;
  localparam int VST  = 3;
  localparam int HSW  = 8;
  localparam int NPIX = HV * VV;
  localparam int S_SEARCH  = 0;
  localparam int S_MEASURE = 1;
  localparam int S_LOCK    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  vga_capture_if vif();

  vga_capture #(
    .hz_visible(HV), .hz_whole(HW), .hz_start(HST),
    .vt_visible(VV), .vt_whole(VW), .vt_start(VST)
  ) dut (
    .CLOCK(clk),
    .RESET(rst),
    .vga(vif)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [11:0] exp_img [NPIX];
  logic [11:0] cap     [NPIX];
  int wr_cnt  = 0;
  int wr_bad  = 0;
  int wr_base = 0;

  int stage;
  bit lk_cur, lk_old, fd_exp, full, frame_err;
  int ll_exp, fl_exp, exp_wr;
  int lines_since_rst, frames_since_rst;

  // scoreboard: each write must be the next address of the frame
  // and carry the pixel the source sent for that position
  always @(negedge clk) begin
    if (!rst && vif.FB_WE) begin
      if (int'(vif.FB_ADDR) < NPIX) begin
        cap[vif.FB_ADDR] = vif.FB_DATA;
        if (vif.FB_ADDR !== 18'(wr_cnt - wr_base) ||
            vif.FB_DATA !== exp_img[vif.FB_ADDR])
          wr_bad++;
      end else begin
        wr_bad++;
      end
      wr_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({vif.FB_WE, vif.FB_ADDR, vif.FB_DATA, vif.FRAME_DONE,
                vif.LOCKED, vif.LINE_LEN, vif.FRAME_LINES});
  endfunction

  function automatic logic [11:0] pat(input int x, input int y);
    if (y >= 8) return 12'h000;
    if (x < 16) return 12'hFFF;
    return 12'h800;
  endfunction

  task automatic drv(input logic hs, input logic vs,
                     input logic [11:0] c);
    vif.VGA_R  = c[11:8];
    vif.VGA_G  = c[7:4];
    vif.VGA_B  = c[3:0];
    vif.VGA_HS = hs;
    vif.VGA_VS = vs;
  endtask

  task automatic model_reset();
    stage = S_SEARCH;
    lk_cur = 0; lk_old = 0; fd_exp = 0;
    full = 0; frame_err = 0;
    lines_since_rst = 0; frames_since_rst = 0;
  endtask

  // One source line: HS rises at p=0, low for the last HSW clocks;
  // pixel X of visible line Y is sent at p = HST+1+X.
  task automatic line(input int l, input int len, input int nl,
                      input int mode, input int stop_p);
    for (int p = 0; p < len; p++) begin
      logic [11:0] c;
      int x, y;
      if (p == stop_p) return;
      c = 12'($urandom);
      x = p - HST - 1;
      y = l - VST;
      if (y >= 0 && y < VV && x >= 0 && x < HV) begin
        if (mode == 1) c = pat(x, y);
        if (lk_cur) begin
          exp_img[y * HV + x] = c;
          exp_wr++;
        end
      end
      drv(p < len - HSW, l >= nl - 2, c);
      @(posedge clk);
      #1;
      if (p == 1) chk("locked_pre", 64'(vif.LOCKED), 64'(lk_old));
      if (p == 2) begin
        chk("locked_post", 64'(vif.LOCKED), 64'(lk_cur));
        chk("frame_done", 64'(vif.FRAME_DONE), 64'(fd_exp));
        if (lines_since_rst >= 2)
          chk("line_len", 64'(vif.LINE_LEN), 64'(ll_exp));
        if (l == 0 && frames_since_rst >= 2)
          chk("frame_lines", 64'(vif.FRAME_LINES), 64'(fl_exp));
      end
      if (p == 3 && fd_exp)
        chk("frame_done_1clk", 64'(vif.FRAME_DONE), 64'd0);
      if (len > 2 * HW && stage == S_LOCK && p == 98)
        chk("wdog_hold", 64'(vif.LOCKED), 64'd1);
      if (len > 2 * HW && stage == S_LOCK && p == 99) begin
        chk("wdog_drop", 64'(vif.LOCKED), 64'd0);
        stage = S_SEARCH;
        full = 0;
        lk_cur = 0;
      end
    end
    // line end: next HS rise (and VS fall at a frame end) is judged
    lines_since_rst++;
    ll_exp = len;
    lk_old = (stage == S_LOCK);
    fd_exp = 0;
    if (l == nl - 1) begin
      frames_since_rst++;
      fl_exp = nl;
      if (stage == S_SEARCH) begin
        stage = S_MEASURE;
      end else if (stage == S_MEASURE) begin
        if (!frame_err && len == HW && nl == VW) stage = S_LOCK;
      end else begin
        fd_exp = full && len == HW && nl == VW;
        if (len != HW || nl != VW) stage = S_SEARCH;
      end
      full = (stage == S_LOCK);
      frame_err = 0;
    end else if (len != HW) begin
      if (stage == S_LOCK) begin
        stage = S_SEARCH;
        full = 0;
      end else if (stage == S_MEASURE) begin
        frame_err = 1;
      end
    end
    lk_cur = (stage == S_LOCK);
  endtask

  task automatic reset_mid();
    rst = 1'b1;
    #1;
    chk("rst_now", 64'({vif.FB_WE, vif.LOCKED}), 64'd0);
    drv(1'b1, 1'b0, 12'h000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst_hold", outs(), 64'd0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic frame(input int nl, input int short_l,
                       input int hold_l, input int mode,
                       input int rst_l);
    int len;
    wr_base = wr_cnt;
    exp_wr = 0;
    for (int l = 0; l < nl; l++) begin
      len = HW;
      if (l == short_l) len = HW - 1;
      if (l == hold_l) len = 2 * HW + 24;
      if (l == rst_l) begin
        line(l, len, nl, mode, 25);
        reset_mid();
        return;
      end
      line(l, len, nl, mode, -1);
    end
    chk("frame_writes", 64'(wr_cnt - wr_base), 64'(exp_wr));
    chk("write_content", 64'(wr_bad), 64'd0);
  endtask

  initial begin
    drv(1'b1, 1'b0, 12'h000);
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", outs(), 64'd0);
    rst = 1'b0;

    frame(VW, -1, -1, 0, -1);
    frame(VW, -1, -1, 0, -1);
    chk("no_early_writes", 64'(wr_cnt), 64'd0);
    frame(VW, -1, -1, 1, -1);
    chk("full_frame_writes", 64'(wr_cnt - wr_base), 64'(NPIX));
    chk("pix_0_0", 64'(cap[0]), 64'h FFF);
    chk("pix_17_1", 64'(cap[17 + HV]), 64'h800);
    chk("pix_17_8", 64'(cap[17 + 8 * HV]), 64'h000);
    frame(VW, -1, -1, 0, -1);
    frame(VW, -1, -1, 0, -1);
    chk("line_len_nom", 64'(vif.LINE_LEN), 64'(HW));
    chk("frame_lines_nom", 64'(vif.FRAME_LINES), 64'(VW));

    frame(VW, 5, -1, 0, -1);
    frame(VW, -1, -1, 0, -1);
    frame(VW, -1, -1, 0, -1);
    frame(VW, -1, -1, 0, -1);

    frame(VW, -1, 1, 0, -1);
    frame(VW, -1, -1, 0, -1);
    frame(VW, -1, -1, 0, -1);
    frame(VW, -1, -1, 0, -1);

    frame(VW, -1, -1, 0, 6);
    frame(VW, -1, -1, 0, -1);
    frame(VW, -1, -1, 0, -1);
    frame(VW, -1, -1, 1, -1);

    for (int f = 0; f < 4; f++)
      frame(VW + 1, -1, -1, 0, -1);
    line(0, HW, VW + 1, 0, -1);
    chk("frame_lines_long", 64'(vif.FRAME_LINES), 64'(VW + 1));
    chk("never_locked", 64'(vif.LOCKED), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
